// File: rtl/bus_seq_pkg.sv
// Shared definitions for the bus sequencer: opcode values, bus-source bit
// positions on the shared 32-bit bus, the sequencer state enum and small
// opcode-classification helpers used by the output decode.
package bus_seq_pkg;

    localparam int SRC_W = 25;

    // Opcodes recognised by the datapath
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_ADDI = 5'd9;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    // Bus-source bit positions; R0..R15 occupy bits 0..15
    localparam logic [4:0] SRC_R0     = 5'd0;
    localparam logic [4:0] SRC_HI     = 5'd16;
    localparam logic [4:0] SRC_LO     = 5'd17;
    localparam logic [4:0] SRC_ZHIGH  = 5'd18;
    localparam logic [4:0] SRC_ZLOW   = 5'd19;
    localparam logic [4:0] SRC_PC     = 5'd20;
    localparam logic [4:0] SRC_MDR    = 5'd21;
    localparam logic [4:0] SRC_INPORT = 5'd22;
    localparam logic [4:0] SRC_CSIGN  = 5'd23;

    // Indices at or above this limit never select a bus source
    localparam int SRC_LIMIT = 24;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
    } seqState_e;

    function automatic logic isLegalOp(input logic [4:0] op);
        return (op <= OP_ADDI) || (op == OP_MUL) || (op == OP_DIV) ||
               (op == OP_NEG) || (op == OP_NOT);
    endfunction

    // mul/div produce a 64-bit result split across LO and HI
    function automatic logic isWideOp(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // neg/not take their only operand from rb in the ALU step
    function automatic logic isUnaryOp(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/bus_sequencer_src_onehot.sv
// Converts a 5-bit source index into a one-hot select vector of OUT_W bits.
// Ports:
//   index  - source number to select
//   enable - when low, the output is all zero
//   oneHot - one-hot select; indices >= 24 (or >= OUT_W) give all zero
module src_onehot
#(
    parameter int OUT_W = 25
)
(
    input  logic [4:0]       index,
    input  logic             enable,
    output logic [OUT_W-1:0] oneHot
);
    import bus_seq_pkg::*;

    // Bit positions at or above SRC_LIMIT are never driven, which keeps the
    // reserved bus-source bit permanently low.
    always_comb begin
        oneHot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            oneHot[i] = enable && (i < SRC_LIMIT) && (index == 5'(i));
        end
    end

endmodule

// File: rtl/bus_sequencer.sv
// Multi-cycle control sequencer for the shared 32-bit datapath bus. Steps
// each instruction through fetch (T0-T2) and execute (T3-T6), driving one
// bus source, the register load enables and the ALU operation per cycle.
// Ports:
//   clock, clear_n      - rising-edge clock, async active-low reset
//   start               - begin an instruction (sampled only in IDLE)
//   ir                  - instruction register: op[31:27] ra[26:23] rb[22:19] rc[18:15]
//   mem_ready           - memory read data valid (ends the T1 wait)
//   rout                - one-hot bus source select
//   rin                 - general register load enables
//   pc_in..lo_in        - special register load enables
//   inc_pc, read        - ALU PC+1 request, memory read request
//   alu_op              - ALU operation (opcode during T4)
//   busy, done, err     - not-idle, completion pulse, sticky illegal opcode
module bus_sequencer
#(
    parameter int SRC_W = 25
)
(
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [31:0]      ir,
    input  logic             mem_ready,
    output logic [SRC_W-1:0] rout,
    output logic [15:0]      rin,
    output logic             pc_in,
    output logic             ir_in,
    output logic             mar_in,
    output logic             mdr_in,
    output logic             y_in,
    output logic             z_in,
    output logic             hi_in,
    output logic             lo_in,
    output logic             inc_pc,
    output logic             read,
    output logic [4:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import bus_seq_pkg::*;

    seqState_e  state;
    seqState_e  nextState;
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic [4:0] srcIdx;
    logic       srcEn;
    logic [4:0] rinIdx;
    logic       rinEn;
    logic       errSet;
    logic       unusedIrBits;

    assign opcode       = ir[31:27];
    assign ra           = ir[26:23];
    assign rb           = ir[22:19];
    assign rc           = ir[18:15];
    assign unusedIrBits = ^ir[14:0];

    // State register; reset abandons any instruction in flight at once.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Sticky illegal-opcode flag, cleared by the next accepted start.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (errSet) begin
            err <= 1'b1;
        end
    end

    // Next-state and Moore output decode. The bus source and the general
    // register target are produced as indices and expanded to one-hot below.
    always_comb begin
        nextState = state;
        srcEn     = 1'b0;
        srcIdx    = SRC_R0;
        rinEn     = 1'b0;
        rinIdx    = 5'd0;
        errSet    = 1'b0;
        pc_in     = 1'b0;
        ir_in     = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        y_in      = 1'b0;
        z_in      = 1'b0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        inc_pc    = 1'b0;
        read      = 1'b0;
        alu_op    = 5'd0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) nextState = T0;
            end
            T0: begin
                srcEn     = 1'b1;
                srcIdx    = SRC_PC;
                mar_in    = 1'b1;
                inc_pc    = 1'b1;
                z_in      = 1'b1;
                nextState = T1;
            end
            T1: begin
                // PC reload from ZLow repeats harmlessly while memory waits
                srcEn  = 1'b1;
                srcIdx = SRC_ZLOW;
                pc_in  = 1'b1;
                read   = 1'b1;
                mdr_in = 1'b1;
                if (mem_ready) nextState = T2;
            end
            T2: begin
                srcEn     = 1'b1;
                srcIdx    = SRC_MDR;
                ir_in     = 1'b1;
                nextState = T3;
            end
            T3: begin
                if (!isLegalOp(opcode)) begin
                    errSet    = 1'b1;
                    nextState = IDLE;
                end else begin
                    srcEn     = 1'b1;
                    srcIdx    = {1'b0, rb};
                    y_in      = 1'b1;
                    nextState = T4;
                end
            end
            T4: begin
                srcEn  = 1'b1;
                z_in   = 1'b1;
                alu_op = opcode;
                if (opcode == OP_ADDI) begin
                    srcIdx = SRC_CSIGN;
                end else if (isUnaryOp(opcode)) begin
                    srcIdx = {1'b0, rb};
                end else begin
                    srcIdx = {1'b0, rc};
                end
                nextState = T5;
            end
            T5: begin
                srcEn  = 1'b1;
                srcIdx = SRC_ZLOW;
                if (isWideOp(opcode)) begin
                    lo_in     = 1'b1;
                    nextState = T6;
                end else begin
                    rinEn     = 1'b1;
                    rinIdx    = {1'b0, ra};
                    nextState = DONE;
                end
            end
            T6: begin
                srcEn     = 1'b1;
                srcIdx    = SRC_ZHIGH;
                hi_in     = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    src_onehot #(.OUT_W(SRC_W)) uRoutDecode (
        .index  (srcIdx),
        .enable (srcEn),
        .oneHot (rout)
    );

    src_onehot #(.OUT_W(16)) uRinDecode (
        .index  (rinIdx),
        .enable (rinEn),
        .oneHot (rin)
    );

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer. A transaction-level model turns an
// instruction word and a memory wait count into the expected per-cycle output
// trace; each scenario task runs the DUT and compares the trace inline.
module tb_bus_sequencer;

    typedef logic [57:0] outVec_t;

    localparam logic [7:0] EN_PC  = 8'h80;
    localparam logic [7:0] EN_IR  = 8'h40;
    localparam logic [7:0] EN_MAR = 8'h20;
    localparam logic [7:0] EN_MDR = 8'h10;
    localparam logic [7:0] EN_Y   = 8'h08;
    localparam logic [7:0] EN_Z   = 8'h04;
    localparam logic [7:0] EN_HI  = 8'h02;
    localparam logic [7:0] EN_LO  = 8'h01;
    localparam logic [7:0] EN_NONE = 8'h00;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        mem_ready = 1'b1;
    logic [24:0] rout;
    logic [15:0] rin;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
    logic        inc_pc, read, busy, done, err;
    logic [4:0]  alu_op;

    int checks = 0;
    int passes = 0;

    outVec_t expQ[$];
    outVec_t obsQ[$];
    logic    expErrQ[$];
    logic    obsErrQ[$];

    bus_sequencer #(.SRC_W(25)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .ir        (ir),
        .mem_ready (mem_ready),
        .rout      (rout),
        .rin       (rin),
        .pc_in     (pc_in),
        .ir_in     (ir_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .hi_in     (hi_in),
        .lo_in     (lo_in),
        .inc_pc    (inc_pc),
        .read      (read),
        .alu_op    (alu_op),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Watchdog so a wedged run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outVec_t obsVec();
        return {rout, rin, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
                inc_pc, read, alu_op, busy, done};
    endfunction

    function automatic outVec_t mk(input int src, input int rinI, input logic [7:0] en,
                                   input logic incPc, input logic rd, input logic [4:0] alu,
                                   input logic bsy, input logic dn);
        logic [24:0] r;
        logic [15:0] g;
        r = 25'd0;
        g = 16'd0;
        if (src >= 0) r = 25'd1 << src;
        if (rinI >= 0) g = 16'd1 << rinI;
        return {r, g, en, incPc, rd, alu, bsy, dn};
    endfunction

    // Expected cycle-by-cycle outputs from T0 through the first IDLE cycle.
    task automatic buildTrace(input logic [31:0] instr, input int waits);
        int op, ra, rb, rc, aluSrc;
        bit legal, wide;
        op = int'(instr[31:27]);
        ra = int'(instr[26:23]);
        rb = int'(instr[22:19]);
        rc = int'(instr[18:15]);
        legal = (op <= 9) || (op == 15) || (op == 16) || (op == 17) || (op == 18);
        wide  = (op == 15) || (op == 16);
        if (op == 9) aluSrc = 23;
        else if (op == 17 || op == 18) aluSrc = rb;
        else aluSrc = rc;
        expQ.delete();
        expErrQ.delete();
        expQ.push_back(mk(20, -1, EN_MAR | EN_Z, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0));
        for (int w = 0; w <= waits; w++)
            expQ.push_back(mk(19, -1, EN_PC | EN_MDR, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0));
        expQ.push_back(mk(21, -1, EN_IR, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
        if (!legal) begin
            expQ.push_back(mk(-1, -1, EN_NONE, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
        end else begin
            expQ.push_back(mk(rb, -1, EN_Y, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
            expQ.push_back(mk(aluSrc, -1, EN_Z, 1'b0, 1'b0, 5'(op), 1'b1, 1'b0));
            if (wide) begin
                expQ.push_back(mk(19, -1, EN_LO, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
                expQ.push_back(mk(18, -1, EN_HI, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
            end else begin
                expQ.push_back(mk(19, ra, EN_NONE, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
            end
            expQ.push_back(mk(-1, -1, EN_NONE, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1));
        end
        expQ.push_back(mk(-1, -1, EN_NONE, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
        for (int i = 0; i < expQ.size(); i++)
            expErrQ.push_back((i == expQ.size() - 1) ? !legal : 1'b0);
    endtask

    // Starts one instruction from an IDLE negedge and records every cycle's
    // outputs at the negedge; returns at the negedge of the first IDLE cycle.
    task automatic applyStimulus(input logic [31:0] instr, input int waits, input bit randomStart);
        int n;
        n = expQ.size();
        obsQ.delete();
        obsErrQ.delete();
        start = 1'b1;
        ir = instr;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < n; i++) begin
            obsQ.push_back(obsVec());
            obsErrQ.push_back(err);
            if (i == n - 1) begin
                start = 1'b0;
                mem_ready = 1'b1;
            end else begin
                start = randomStart ? 1'($urandom_range(0, 1)) : 1'b0;
                if (i >= 1 && i <= waits) mem_ready = 1'b0;
                else if (i == waits + 1) mem_ready = 1'b1;
                else mem_ready = 1'($urandom_range(0, 1));
                @(posedge clock);
                @(negedge clock);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obsVec() !== '0 || err !== 1'b0)
            $display("[TB] FAIL reset_outputs: got %h err %b, expected 0 err 0", obsVec(), err);
        else passes++;
        start = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (obsVec() !== '0)
            $display("[TB] FAIL reset_holds: got %h, expected 0", obsVec());
        else passes++;
        start = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);
        checks++;
        if (obsVec() !== '0 || err !== 1'b0)
            $display("[TB] FAIL reset_idle: got %h err %b, expected 0 err 0", obsVec(), err);
        else passes++;
    endtask

    task automatic test_add();
        buildTrace(32'h02920000, 0);
        applyStimulus(32'h02920000, 0, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i])
                $display("[TB] FAIL add cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
            else passes++;
        end
    endtask

    task automatic test_addi();
        buildTrace(32'h48900000, 0);
        applyStimulus(32'h48900000, 0, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i])
                $display("[TB] FAIL addi cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
            else passes++;
        end
    endtask

    task automatic test_mul();
        buildTrace(32'h78188000, 0);
        applyStimulus(32'h78188000, 0, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i])
                $display("[TB] FAIL mul cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
            else passes++;
        end
    endtask

    task automatic test_mem_wait();
        buildTrace(32'h02920000, 3);
        applyStimulus(32'h02920000, 3, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i])
                $display("[TB] FAIL mem_wait cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
            else passes++;
        end
    endtask

    task automatic test_illegal();
        buildTrace(32'hF8000000, 1);
        applyStimulus(32'hF8000000, 1, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i])
                $display("[TB] FAIL illegal cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
            else passes++;
            checks++;
            if (obsErrQ[i] !== expErrQ[i])
                $display("[TB] FAIL illegal_err cycle %0d: got %b expected %b", i, obsErrQ[i], expErrQ[i]);
            else passes++;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (err !== 1'b1 || obsVec() !== '0)
            $display("[TB] FAIL err_sticky: err %b outputs %h, expected err 1 outputs 0", err, obsVec());
        else passes++;
        buildTrace(32'h10A08000, 0);
        applyStimulus(32'h10A08000, 0, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i] || obsErrQ[i] !== expErrQ[i])
                $display("[TB] FAIL err_clear cycle %0d: got %h/%b expected %h/%b",
                         i, obsQ[i], obsErrQ[i], expQ[i], expErrQ[i]);
            else passes++;
        end
    endtask

    task automatic test_mid_reset();
        buildTrace(32'h02920000, 0);
        start = 1'b1;
        ir = 32'h02920000;
        mem_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (obsVec() !== expQ[4])
            $display("[TB] FAIL mid_reset_t4: got %h expected %h", obsVec(), expQ[4]);
        else passes++;
        #2 clear_n = 1'b0;
        #1;
        checks++;
        if (obsVec() !== '0 || err !== 1'b0)
            $display("[TB] FAIL mid_reset_async: got %h err %b, expected 0 err 0", obsVec(), err);
        else passes++;
        @(negedge clock);
        clear_n = 1'b1;
        @(negedge clock);
        checks++;
        if (obsVec() !== '0)
            $display("[TB] FAIL mid_reset_idle: got %h, expected 0", obsVec());
        else passes++;
        applyStimulus(32'h02920000, 0, 1'b0);
        for (int i = 0; i < expQ.size(); i++) begin
            checks++;
            if (obsQ[i] !== expQ[i])
                $display("[TB] FAIL after_reset cycle %0d: got %h expected %h", i, obsQ[i], expQ[i]);
            else passes++;
        end
    endtask

    // Random instructions issued back to back, with stray start pulses while
    // busy and random memory latency; mostly legal opcodes, some illegal.
    task automatic test_back_to_back();
        logic [4:0]  legalOps [14];
        logic [31:0] instr;
        int          waits;
        legalOps = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                     5'd15, 5'd16, 5'd17, 5'd18};
        for (int t = 0; t < 30; t++) begin
            instr = $urandom;
            if ($urandom_range(0, 4) != 0)
                instr[31:27] = legalOps[$urandom_range(0, 13)];
            waits = $urandom_range(0, 3);
            buildTrace(instr, waits);
            applyStimulus(instr, waits, 1'b1);
            for (int i = 0; i < expQ.size(); i++) begin
                checks++;
                if (obsQ[i] !== expQ[i] || obsErrQ[i] !== expErrQ[i])
                    $display("[TB] FAIL random ir %h cycle %0d: got %h/%b expected %h/%b",
                             instr, i, obsQ[i], obsErrQ[i], expQ[i], expErrQ[i]);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_mul();
        test_mem_wait();
        test_illegal();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
